// File: rtl/uart_core_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_core_param
// Description : Single-clock UART with TX and RX datapaths, oversampled RX
//               and clock-enable baud ticks. Optional parity via UART_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_core_param #(
    parameter int WORD_LENGTH = 8,
    parameter int FREQUENCY   = 50000000,
    parameter int BAUDRATE    = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_LENGTH-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx_out,
    input  logic                   rx_in,
    output logic [WORD_LENGTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   frame_err,
    output logic                   parity_err
);

    localparam int c_DIV_RAW = FREQUENCY / (BAUDRATE * OVERSAMPLE);
    localparam int c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
    localparam int c_DIV_W   = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_OS_W    = $clog2(OVERSAMPLE);
    localparam int c_BIT_W   = $clog2(WORD_LENGTH + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(c_DIV - 1);
    localparam logic [c_OS_W-1:0]  c_OS_LAST   = c_OS_W'(OVERSAMPLE - 1);
    localparam logic [c_OS_W-1:0]  c_OS_MID    = c_OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_BIT_W-1:0] c_WORD_LAST = c_BIT_W'(WORD_LENGTH - 1);
    localparam logic [c_BIT_W-1:0] c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);

    localparam logic [2:0] c_TX_IDLE   = 3'd0;
    localparam logic [2:0] c_TX_WAIT   = 3'd1;
    localparam logic [2:0] c_TX_START  = 3'd2;
    localparam logic [2:0] c_TX_DATA   = 3'd3;
    localparam logic [2:0] c_TX_STOP   = 3'd5;

    localparam logic [2:0] c_RX_IDLE   = 3'd0;
    localparam logic [2:0] c_RX_START  = 3'd1;
    localparam logic [2:0] c_RX_DATA   = 3'd2;
    localparam logic [2:0] c_RX_STOP   = 3'd4;

`ifdef UART_PARITY_EN
    localparam logic [2:0] c_TX_PARITY = 3'd4;
    localparam logic [2:0] c_RX_PARITY = 3'd3;
    localparam logic       c_PAR_ODD   = (PARITY_ODD != 0);
`endif

    // ------------------------------------------------------------------------
    // Oversample tick generator shared by TX and RX
    // ------------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_div_cnt;
    logic               w_os_tick;

    assign w_os_tick = (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
        end else if (w_os_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------------
    logic [2:0]             r_tx_state;
    logic                   r_tx_ready;
    logic                   r_tx_out;
    logic [WORD_LENGTH-1:0] r_tx_shift;
    logic [c_OS_W-1:0]      r_tx_os_cnt;
    logic [c_BIT_W-1:0]     r_tx_bit_cnt;
    logic                   w_tx_bit_end;
`ifdef UART_PARITY_EN
    logic                   r_tx_par;
`endif

    assign tx_ready     = r_tx_ready;
    assign tx_out       = r_tx_out;
    assign w_tx_bit_end = w_os_tick && (r_tx_os_cnt == c_OS_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state   <= c_TX_IDLE;
            r_tx_ready   <= 1'b1;
            r_tx_out     <= 1'b1;
            r_tx_shift   <= '0;
            r_tx_os_cnt  <= '0;
            r_tx_bit_cnt <= '0;
`ifdef UART_PARITY_EN
            r_tx_par     <= 1'b0;
`endif
        end else begin
            case (r_tx_state)
                c_TX_IDLE: begin
                    r_tx_out <= 1'b1;
                    if (tx_valid && r_tx_ready) begin
                        r_tx_shift  <= tx_data;
                        r_tx_ready  <= 1'b0;
                        r_tx_os_cnt <= '0;
`ifdef UART_PARITY_EN
                        r_tx_par    <= (^tx_data) ^ c_PAR_ODD;
`endif
                        // Start bit begins on the next tick boundary
                        if (w_os_tick) begin
                            r_tx_out   <= 1'b0;
                            r_tx_state <= c_TX_START;
                        end else begin
                            r_tx_state <= c_TX_WAIT;
                        end
                    end
                end
                c_TX_WAIT: begin
                    if (w_os_tick) begin
                        r_tx_out   <= 1'b0;
                        r_tx_state <= c_TX_START;
                    end
                end
                default: begin
                    if (w_os_tick) begin
                        r_tx_os_cnt <= w_tx_bit_end ? '0 : r_tx_os_cnt + 1'b1;
                    end
                    if (w_tx_bit_end) begin
                        case (r_tx_state)
                            c_TX_START: begin
                                r_tx_out     <= r_tx_shift[0];
                                r_tx_shift   <= r_tx_shift >> 1;
                                r_tx_bit_cnt <= '0;
                                r_tx_state   <= c_TX_DATA;
                            end
                            c_TX_DATA: begin
                                if (r_tx_bit_cnt == c_WORD_LAST) begin
                                    r_tx_bit_cnt <= '0;
`ifdef UART_PARITY_EN
                                    r_tx_out     <= r_tx_par;
                                    r_tx_state   <= c_TX_PARITY;
`else
                                    r_tx_out     <= 1'b1;
                                    r_tx_state   <= c_TX_STOP;
`endif
                                end else begin
                                    r_tx_out     <= r_tx_shift[0];
                                    r_tx_shift   <= r_tx_shift >> 1;
                                    r_tx_bit_cnt <= r_tx_bit_cnt + 1'b1;
                                end
                            end
`ifdef UART_PARITY_EN
                            c_TX_PARITY: begin
                                r_tx_out   <= 1'b1;
                                r_tx_state <= c_TX_STOP;
                            end
`endif
                            c_TX_STOP: begin
                                if (r_tx_bit_cnt == c_STOP_LAST) begin
                                    r_tx_ready <= 1'b1;
                                    r_tx_state <= c_TX_IDLE;
                                end else begin
                                    r_tx_bit_cnt <= r_tx_bit_cnt + 1'b1;
                                end
                            end
                            default: begin
                                r_tx_out   <= 1'b1;
                                r_tx_ready <= 1'b1;
                                r_tx_state <= c_TX_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------------
    logic [1:0]             r_rx_sync;
    logic                   r_rx_prev;
    logic [2:0]             r_rx_state;
    logic [c_OS_W-1:0]      r_rx_os_cnt;
    logic [c_BIT_W-1:0]     r_rx_bit_cnt;
    logic [WORD_LENGTH-1:0] r_rx_shift;
    logic [WORD_LENGTH-1:0] r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;
    logic                   w_rx_line;
    logic                   w_rx_cnt_hit;
    logic                   w_rx_sample;
`ifdef UART_PARITY_EN
    logic                   r_rx_par;
    logic                   r_rx_perr;
    logic                   r_parity_err;
`else
    logic                   w_unused_parity_odd;
    assign w_unused_parity_odd = (PARITY_ODD != 0);
`endif

    assign w_rx_line    = r_rx_sync[1];
    // Start bit is checked at half a bit, every later bit a full bit after that
    assign w_rx_cnt_hit = (r_rx_state == c_RX_START) ? (r_rx_os_cnt == c_OS_MID)
                                                     : (r_rx_os_cnt == c_OS_LAST);
    assign w_rx_sample  = w_os_tick && w_rx_cnt_hit;

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
`ifdef UART_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_sync    <= 2'b11;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= c_RX_IDLE;
            r_rx_os_cnt  <= '0;
            r_rx_bit_cnt <= '0;
            r_rx_shift   <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_par     <= 1'b0;
            r_rx_perr    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_sync   <= {r_rx_sync[0], rx_in};
            r_rx_prev   <= w_rx_line;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (r_rx_state == c_RX_IDLE) begin
                r_rx_os_cnt <= '0;
            end else if (w_os_tick) begin
                r_rx_os_cnt <= w_rx_cnt_hit ? '0 : r_rx_os_cnt + 1'b1;
            end

            case (r_rx_state)
                c_RX_IDLE: begin
                    // Edge-triggered so a held-low line cannot restart a frame
                    if (r_rx_prev && !w_rx_line) begin
                        r_rx_state <= c_RX_START;
                    end
                end
                c_RX_START: begin
                    if (w_rx_sample) begin
                        r_rx_bit_cnt <= '0;
`ifdef UART_PARITY_EN
                        r_rx_par     <= 1'b0;
`endif
                        r_rx_state   <= w_rx_line ? c_RX_IDLE : c_RX_DATA;
                    end
                end
                c_RX_DATA: begin
                    if (w_rx_sample) begin
                        r_rx_shift <= {w_rx_line, r_rx_shift[WORD_LENGTH-1:1]};
`ifdef UART_PARITY_EN
                        r_rx_par   <= r_rx_par ^ w_rx_line;
`endif
                        if (r_rx_bit_cnt == c_WORD_LAST) begin
`ifdef UART_PARITY_EN
                            r_rx_state <= c_RX_PARITY;
`else
                            r_rx_state <= c_RX_STOP;
`endif
                        end else begin
                            r_rx_bit_cnt <= r_rx_bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                c_RX_PARITY: begin
                    if (w_rx_sample) begin
                        r_rx_perr  <= w_rx_line ^ r_rx_par ^ c_PAR_ODD;
                        r_rx_state <= c_RX_STOP;
                    end
                end
`endif
                c_RX_STOP: begin
                    if (w_rx_sample) begin
                        r_rx_data    <= r_rx_shift;
                        r_rx_valid   <= 1'b1;
                        r_frame_err  <= ~w_rx_line;
`ifdef UART_PARITY_EN
                        r_parity_err <= r_rx_perr;
`endif
                        r_rx_state   <= c_RX_IDLE;
                    end
                end
                default: begin
                    r_rx_state <= c_RX_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
